// File: rtl/seg_scan_reader_if.sv
// Display bus plus decoded-contents bundle for seg_scan_reader.
// The scan driver (or bench) is the master; the reader is the slave.
interface seg_scan_reader_if #(
    parameter int N_DIGITS = 8
) ();
    logic [N_DIGITS-1:0]   an_n;
    logic [6:0]            seg_n;
    logic [4*N_DIGITS-1:0] digits;
    logic [N_DIGITS-1:0]   digit_valid;
    logic [N_DIGITS-1:0]   digit_err;
    logic                  update;
    logic [2:0]            update_idx;
    logic                  frame_done;

    modport master (
        output an_n, seg_n,
        input  digits, digit_valid, digit_err, update, update_idx, frame_done
    );

    modport slave (
        input  an_n, seg_n,
        output digits, digit_valid, digit_err, update, update_idx, frame_done
    );
endinterface

// File: rtl/seg_scan_reader.sv
// Passive reader for a multiplexed active-low 7-segment bus: waits for each
// digit to settle, inverse-decodes it and rebuilds the displayed hex word.
module seg_scan_reader #(
    parameter int N_DIGITS      = 8,
    parameter int STABLE_CYCLES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    seg_scan_reader_if.slave bus
);

    typedef enum logic [1:0] {S_WAIT, S_COUNT, S_HOLD} state_t;

    // {hit, nibble}; hit=0 means the pattern is not a hex glyph
    function automatic logic [4:0] f_decode(input logic [6:0] seg);
        case (seg)
            7'b0000001: f_decode = 5'h10;
            7'b1001111: f_decode = 5'h11;
            7'b0010010: f_decode = 5'h12;
            7'b0000110: f_decode = 5'h13;
            7'b1001100: f_decode = 5'h14;
            7'b0100100: f_decode = 5'h15;
            7'b0100000: f_decode = 5'h16;
            7'b0001111: f_decode = 5'h17;
            7'b0000000: f_decode = 5'h18;
            7'b0000100: f_decode = 5'h19;
            7'b0001000: f_decode = 5'h1A;
            7'b1100000: f_decode = 5'h1B;
            7'b0110001: f_decode = 5'h1C;
            7'b1000010: f_decode = 5'h1D;
            7'b0110000: f_decode = 5'h1E;
            7'b0111000: f_decode = 5'h1F;
            default:    f_decode = 5'h00;
        endcase
    endfunction

    logic [N_DIGITS-1:0]   r_an_p0, r_an_p1;
    logic [6:0]            r_seg_p0, r_seg_p1;
    state_t                r_state;
    logic [2:0]            r_idx;
    logic [6:0]            r_seg;
    logic [7:0]            r_cnt;
    logic [N_DIGITS-1:0]   r_mask;
    logic [4*N_DIGITS-1:0] r_digits;
    logic [N_DIGITS-1:0]   r_valid;
    logic [N_DIGITS-1:0]   r_err;
    logic                  r_update;
    logic [2:0]            r_update_idx;
    logic                  r_frame_done;

    logic [3:0]            w_zeros;
    logic [2:0]            w_idx;
    logic                  w_single;
    logic                  w_same;
    logic                  w_commit;
    logic [4:0]            w_dec;
    logic [N_DIGITS-1:0]   w_mask_next;

    // Two-flop synchronizers; idle (all-ones) is the reset value
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_an_p0  <= '1;
            r_an_p1  <= '1;
            r_seg_p0 <= '1;
            r_seg_p1 <= '1;
        end else begin
            r_an_p0  <= bus.an_n;
            r_an_p1  <= r_an_p0;
            r_seg_p0 <= bus.seg_n;
            r_seg_p1 <= r_seg_p0;
        end
    end

    always_comb begin
        w_zeros = 4'd0;
        w_idx   = 3'd0;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (!r_an_p1[i]) begin
                w_zeros = w_zeros + 4'd1;
                w_idx   = 3'(i);
            end
        end
    end

    assign w_single    = (w_zeros == 4'd1);
    assign w_same      = (w_idx == r_idx) && (r_seg_p1 == r_seg);
    assign w_commit    = (r_state == S_COUNT) && w_single && w_same &&
                         (r_cnt == 8'(STABLE_CYCLES - 1));
    assign w_dec       = f_decode(r_seg_p1);
    assign w_mask_next = r_mask | (N_DIGITS'(1) << w_idx);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_WAIT;
            r_idx   <= '0;
            r_seg   <= '1;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                S_WAIT: begin
                    if (w_single) begin
                        r_idx   <= w_idx;
                        r_seg   <= r_seg_p1;
                        r_cnt   <= 8'd1;
                        r_state <= S_COUNT;
                    end
                end
                S_COUNT: begin
                    if (!w_single) begin
                        r_state <= S_WAIT;
                    end else if (!w_same) begin
                        r_idx <= w_idx;
                        r_seg <= r_seg_p1;
                        r_cnt <= 8'd1;
                    end else if (w_commit) begin
                        r_cnt   <= 8'(STABLE_CYCLES);
                        r_state <= S_HOLD;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                S_HOLD: begin
                    if (!w_single) begin
                        r_state <= S_WAIT;
                    end else if (!w_same) begin
                        r_idx   <= w_idx;
                        r_seg   <= r_seg_p1;
                        r_cnt   <= 8'd1;
                        r_state <= S_COUNT;
                    end
                end
                default: r_state <= S_WAIT;
            endcase
        end
    end

    // Commit: the mask tracks every slot touched, whatever the outcome
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_digits     <= '0;
            r_valid      <= '0;
            r_err        <= '0;
            r_update     <= 1'b0;
            r_update_idx <= '0;
            r_frame_done <= 1'b0;
            r_mask       <= '0;
        end else begin
            r_update     <= 1'b0;
            r_frame_done <= 1'b0;
            if (w_commit) begin
                r_update     <= 1'b1;
                r_update_idx <= w_idx;
                if (w_dec[4]) begin
                    r_digits[4*w_idx +: 4] <= w_dec[3:0];
                    r_valid[w_idx]         <= 1'b1;
                    r_err[w_idx]           <= 1'b0;
                end else begin
                    r_valid[w_idx] <= 1'b0;
                    r_err[w_idx]   <= (r_seg_p1 != 7'b1111111);
                end
                if (&w_mask_next) begin
                    r_frame_done <= 1'b1;
                    r_mask       <= '0;
                end else begin
                    r_mask <= w_mask_next;
                end
            end
        end
    end

    assign bus.digits      = r_digits;
    assign bus.digit_valid = r_valid;
    assign bus.digit_err   = r_err;
    assign bus.update      = r_update;
    assign bus.update_idx  = r_update_idx;
    assign bus.frame_done  = r_frame_done;

endmodule
